// File: rtl/btn_dir_conditioner_pkg.sv
// Shared direction encoding for the button conditioner, ghost control and position update.
// Directions are 4-bit one-hot: bit3=up, bit2=down, bit1=left, bit0=right.
package btn_dir_conditioner_pkg;

  localparam int unsigned NumBtns = 4;

  localparam int unsigned BitUp    = 3;
  localparam int unsigned BitDown  = 2;
  localparam int unsigned BitLeft  = 1;
  localparam int unsigned BitRight = 0;

  localparam logic [NumBtns-1:0] DIR_NONE  = 4'b0000;
  localparam logic [NumBtns-1:0] DIR_UP    = 4'b1000;
  localparam logic [NumBtns-1:0] DIR_DOWN  = 4'b0100;
  localparam logic [NumBtns-1:0] DIR_LEFT  = 4'b0010;
  localparam logic [NumBtns-1:0] DIR_RIGHT = 4'b0001;

  // Highest-priority pressed direction (up > down > left > right); keeps cur when nothing pressed.
  function automatic logic [NumBtns-1:0] dir_select(input logic [NumBtns-1:0] press,
                                                    input logic [NumBtns-1:0] cur);
    logic [NumBtns-1:0] dir;
    if (press[BitUp]) begin
      dir = DIR_UP;
    end else if (press[BitDown]) begin
      dir = DIR_DOWN;
    end else if (press[BitLeft]) begin
      dir = DIR_LEFT;
    end else if (press[BitRight]) begin
      dir = DIR_RIGHT;
    end else begin
      dir = cur;
    end
    return dir;
  endfunction

endpackage

// File: rtl/btn_dir_conditioner_if.sv
// Button inputs and conditioned direction outputs of the button conditioner.
// The conditioner sits on the slave side; the button/board side drives the master side.
interface btn_dir_conditioner_if;
  import btn_dir_conditioner_pkg::*;

  logic                rbtn;
  logic                lbtn;
  logic                ubtn;
  logic                dbtn;
  logic [NumBtns-1:0]  btn_press;
  logic [NumBtns-1:0]  move_dir;
  logic                move_tick;

  modport master (
    output rbtn, lbtn, ubtn, dbtn,
    input  btn_press, move_dir, move_tick
  );

  modport slave (
    input  rbtn, lbtn, ubtn, dbtn,
    output btn_press, move_dir, move_tick
  );

endinterface

// File: rtl/btn_debounce.sv
// One push-button channel: 2-flop synchronizer, counting debouncer and rising-edge pulse.
// The stable level flips only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_press
);

  localparam int unsigned     CntW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            stable_q;
  logic            stable_d;
  logic            stable_dly_q;
  logic            press_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  // Counter never passes CntLast: reaching it with the input still different flips the level.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntLast) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
      press_q      <= stable_q & ~stable_dly_q;
    end
  end

  assign btn_press = press_q;

endmodule

// File: rtl/btn_dir_conditioner.sv
// Debounces four direction buttons and turns presses into a latched move direction
// that is applied to the output only on periodic move ticks.
module btn_dir_conditioner
  import btn_dir_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned TICK_DIV        = 1666667
) (
  input  logic                  clk,
  input  logic                  rst,
  btn_dir_conditioner_if.slave  bus
);

  localparam int unsigned      TickW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);

  logic [NumBtns-1:0] btn_raw;
  logic [NumBtns-1:0] btn_press;
  logic [NumBtns-1:0] pending_q;
  logic [NumBtns-1:0] pending_d;
  logic [NumBtns-1:0] move_dir_q;
  logic [NumBtns-1:0] move_dir_d;
  logic [TickW-1:0]   tick_cnt_q;
  logic [TickW-1:0]   tick_cnt_d;
  logic               move_tick;

  assign btn_raw[BitUp]    = bus.ubtn;
  assign btn_raw[BitDown]  = bus.dbtn;
  assign btn_raw[BitLeft]  = bus.lbtn;
  assign btn_raw[BitRight] = bus.rbtn;

  for (genvar i = 0; i < NumBtns; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw[i]),
      .btn_press (btn_press[i])
    );
  end

  assign move_tick = (tick_cnt_q == TickLast);

  always_comb begin
    tick_cnt_d = move_tick ? '0 : tick_cnt_q + 1'b1;
    pending_d  = dir_select(btn_press, pending_q);
    // A press arriving in the tick cycle is applied at that same tick.
    move_dir_d = move_tick ? pending_d : move_dir_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
      pending_q  <= DIR_NONE;
      move_dir_q <= DIR_NONE;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      pending_q  <= pending_d;
      move_dir_q <= move_dir_d;
    end
  end

  assign bus.btn_press = btn_press;
  assign bus.move_dir  = move_dir_q;
  assign bus.move_tick = move_tick;

endmodule

// File: tb/tb_btn_dir_conditioner.sv
// Self-checking bench for btn_dir_conditioner with DEBOUNCE_CYCLES=4, TICK_DIV=8.
// A history-window reference model checks every cycle; directed tables/sequences cover corners.
module tb_btn_dir_conditioner;

  localparam int unsigned Dc   = 4;
  localparam int unsigned Td   = 8;
  localparam int          MaxT = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;

  btn_dir_conditioner_if bus ();

  btn_dir_conditioner #(
    .DEBOUNCE_CYCLES (Dc),
    .TICK_DIV        (Td)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: raw level sampled at each edge, per button (bit3=up .. bit0=right).
  bit         hist     [4][MaxT];
  bit         stable_m [4];
  int         last_tog [4];
  bit         rose_m   [4];
  logic [3:0] press_m;
  logic [3:0] pend_m;
  logic [3:0] move_m;
  int         tcnt_m;
  int         t = 1;

  typedef struct {
    bit         rst;
    logic [3:0] raw;
    logic [3:0] press;
    logic [3:0] dir;
    bit         tick;
  } vec_t;

  vec_t vecs [30];

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%b exp=%b", name, t, got, exp);
    end
  endtask

  function automatic logic [3:0] pick_dir(input logic [3:0] p, input logic [3:0] cur);
    logic [3:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) if (p[b]) res = 4'b0001 << b;
    return res;
  endfunction

  // Advance one clock edge with the given inputs, update the model, compare all outputs.
  task automatic step(input bit r, input logic [3:0] raw);
    bit ok;
    rst      = r;
    bus.ubtn = raw[3];
    bus.dbtn = raw[2];
    bus.lbtn = raw[1];
    bus.rbtn = raw[0];
    @(posedge clk);
    #1;
    t++;
    if (t >= MaxT) begin
      $display("FAIL model_range t=%0d got=%0d exp<%0d", t, t, MaxT);
      $fatal(1);
    end
    if (r) begin
      for (int b = 0; b < 4; b++) begin
        hist[b][t]     = 1'b0;
        hist[b][t - 1] = 1'b0;
        stable_m[b]    = 1'b0;
        last_tog[b]    = t;
        rose_m[b]      = 1'b0;
      end
      press_m = 4'b0000;
      pend_m  = 4'b0000;
      move_m  = 4'b0000;
      tcnt_m  = 0;
    end else begin
      pend_m = pick_dir(press_m, pend_m);
      if (tcnt_m == Td - 1) move_m = pend_m;
      tcnt_m = (tcnt_m + 1) % Td;
      for (int b = 0; b < 4; b++) begin
        press_m[b] = rose_m[b];
        rose_m[b]  = 1'b0;
        // Level flips once the synchronized input has disagreed for Dc edges in a row.
        ok = (t - last_tog[b] >= Dc);
        for (int k = 0; k < Dc; k++) if (ok && hist[b][t - 2 - k] == stable_m[b]) ok = 1'b0;
        if (ok) begin
          stable_m[b] = ~stable_m[b];
          last_tog[b] = t;
          rose_m[b]   = stable_m[b];
        end
        hist[b][t] = raw[b];
      end
    end
    check("model_press", bus.btn_press, press_m);
    check("model_dir", bus.move_dir, move_m);
    check("model_tick", {3'b000, bus.move_tick}, {3'b000, tcnt_m == Td - 1});
  endtask

  initial begin
    int         cnt;
    logic [3:0] raw;
    logic [3:0] dir_before;

    bus.ubtn = 1'b0;
    bus.dbtn = 1'b0;
    bus.lbtn = 1'b0;
    bus.rbtn = 1'b0;

    // Entry i drives inputs before edge i; edge 0 is reset. ubtn rises after edge 10.
    for (int i = 0; i < 30; i++) begin
      vecs[i].rst   = (i == 0);
      vecs[i].raw   = (i >= 11) ? 4'b1000 : 4'b0000;
      vecs[i].press = (i == 17) ? 4'b1000 : 4'b0000;
      vecs[i].dir   = (i >= 24) ? 4'b1000 : 4'b0000;
      vecs[i].tick  = (i > 0) && (i % 8 == 7);
    end

    for (int i = 0; i < 30; i++) begin
      step(vecs[i].rst, vecs[i].raw);
      check("tbl_press", bus.btn_press, vecs[i].press);
      check("tbl_dir", bus.move_dir, vecs[i].dir);
      check("tbl_tick", {3'b000, bus.move_tick}, {3'b000, vecs[i].tick});
    end

    // Release produces no pulse.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'b0000);
      check("release_nopulse", bus.btn_press, 4'b0000);
    end

    // Bounce on rbtn shorter than the debounce window.
    for (int i = 0; i < 20; i++) begin
      step(1'b0, ((i / 2) % 2 == 0) ? 4'b0001 : 4'b0000);
      check("bounce_press", bus.btn_press, 4'b0000);
      check("bounce_dir", bus.move_dir, 4'b1000);
    end

    // Simultaneous up+right: one combined pulse, up wins, persists after release.
    step(1'b1, 4'b0000);
    for (int i = 0; i < 4; i++) step(1'b0, 4'b0000);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 4'b1001);
      if (bus.btn_press == 4'b1001) cnt++;
      else check("dual_other", bus.btn_press, 4'b0000);
    end
    check("dual_pulse_count", cnt[3:0], 4'd1);
    check("dual_dir", bus.move_dir, 4'b1000);
    for (int i = 0; i < 20; i++) step(1'b0, 4'b0000);
    check("dual_hold", bus.move_dir, 4'b1000);

    // lbtn press landing exactly on the tick cycle.
    for (int i = 0; i < Td && tcnt_m != 0; i++) step(1'b0, 4'b0000);
    check("tick_align", tcnt_m[3:0], 4'd0);
    dir_before = bus.move_dir;
    for (int i = 0; i < 7; i++) step(1'b0, 4'b0010);
    check("ontick_press", bus.btn_press, 4'b0010);
    check("ontick_tick", {3'b000, bus.move_tick}, 4'b0001);
    check("ontick_dir_before", bus.move_dir, dir_before);
    step(1'b0, 4'b0010);
    check("ontick_dir", bus.move_dir, 4'b0010);

    // Reset two cycles before dbtn would qualify; full re-qualification afterwards.
    for (int i = 0; i < 10; i++) step(1'b0, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b0100);
      check("rstq_pre", bus.btn_press, 4'b0000);
    end
    step(1'b1, 4'b0100);
    check("rstq_rst_press", bus.btn_press, 4'b0000);
    check("rstq_rst_dir", bus.move_dir, 4'b0000);
    check("rstq_rst_tick", {3'b000, bus.move_tick}, 4'b0000);
    for (int i = 1; i <= 7; i++) begin
      step(1'b0, 4'b0100);
      check("rstq_press", bus.btn_press, (i == 7) ? 4'b0100 : 4'b0000);
      check("rstq_dir", bus.move_dir, 4'b0000);
    end
    step(1'b0, 4'b0100);
    check("rstq_dir_tick", bus.move_dir, 4'b0100);

    // Random bouncing buttons with occasional resets, checked against the model only.
    raw = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(4) == 0) raw[b] = ~raw[b];
      step($urandom_range(149) == 0, raw);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_dir_conditioner.md
BTN_DIR_CONDITIONER -- requirements
Module: btn_dir_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, stable-input cycles required to accept a level change (>=2).
REQ-002 Parameter TICK_DIV, default 1666667, clock cycles per move tick (>=2).
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rbtn, lbtn, ubtn, dbtn  input  1 each  raw, asynchronous, bouncing push-buttons, active-high.
REQ-006 btn_press  output  4  one-cycle pulse per debounced rising edge, bit3=up, bit2=down, bit1=left, bit0=right.
REQ-007 move_dir  output  4  one-hot direction applied for the current move step, same bit order, 4'b0000 = stopped.
REQ-008 move_tick  output  1  one-cycle pulse marking a move step for the downstream position-update stage.

Function
REQ-009 Each raw button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-010 Each debouncer SHALL hold a stable level and a counter; the counter clears whenever the synchronized input equals the stable level, else increments.
REQ-011 The stable level SHALL toggle, and the counter clear, on the cycle the counter reaches DEBOUNCE_CYCLES-1 with the input still differing.
REQ-012 btn_press[i] SHALL pulse high for exactly one cycle, the cycle after stable level i goes 0->1; release produces no pulse.
REQ-013 A raw level held from edge N SHALL produce btn_press at edge N+DEBOUNCE_CYCLES+3; any bounce shorter than DEBOUNCE_CYCLES produces no pulse.
REQ-014 Pending direction register SHALL load the one-hot code of any btn_press; multiple pulses in one cycle resolve by priority up > down > left > right.
REQ-015 Pending direction SHALL persist after button release (no auto-stop); only a new press or reset changes it.
REQ-016 Tick counter SHALL count 0..TICK_DIV-1 and wrap to 0; move_tick is high exactly when the counter equals TICK_DIV-1.
REQ-017 move_dir SHALL update only on edges where move_tick is high, loading the pending direction's next value (a press in the tick cycle takes effect at that tick).
REQ-018 move_dir SHALL hold its value between ticks regardless of button activity.
REQ-019 Counter widths SHALL be sized by clog2 of the parameter; no counter may overflow or saturate silently.

Reset
REQ-020 On rst high at a clock edge: synchronizer flops, stable levels, debounce counters, tick counter, pending direction cleared to 0.
REQ-021 Outputs after reset: btn_press=4'b0000, move_dir=4'b0000, move_tick=0.
REQ-022 Reset mid-debounce SHALL discard the partial count; a held button re-qualifies in full DEBOUNCE_CYCLES after rst deasserts.
REQ-023 First move_tick after reset release SHALL occur TICK_DIV cycles after the first non-reset edge.

Structure
REQ-024 Shared package SHALL hold direction constants DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT (4-bit one-hot) used also by ghost control and position update.
REQ-025 One sub-module btn_debounce (synchronizer + debouncer + rise pulse) SHALL be instantiated four times; tick counter and direction registers live in the top.

Verification (DEBOUNCE_CYCLES=4, TICK_DIV=8)
REQ-026 Reset then idle 20 cycles -> all outputs 0, move_tick at cycles 8 and 16 only.
REQ-027 ubtn high from edge 10, held -> btn_press=4'b1000 single pulse at edge 17; move_dir=4'b1000 from next tick.
REQ-028 rbtn toggling every 2 cycles for 20 cycles -> no btn_press pulse, move_dir unchanged.
REQ-029 ubtn and rbtn raised on same edge -> single-cycle btn_press=4'b1001, pending and move_dir=4'b1000 at next tick; release both -> move_dir stays 4'b1000.
REQ-030 lbtn press timed so btn_press lands on a move_tick cycle -> move_dir=4'b0010 from that same edge.
REQ-031 rst asserted 2 cycles before a pending qualification -> no pulse; held button pulses DEBOUNCE_CYCLES+3 cycles after rst release, move_dir 0 until following tick.
